// File: rtl/freq_divide_3.sv
// Divide-by-3 clock generator with 50% duty: posedge and negedge mod-3 counters, terminal decodes ORed.
// Optional build macro FREQ_DIV3_ENABLE_EN adds an 'en' input that freezes both counters when low.
module freq_divide_3 (
  output logic       clk_out,
  output logic [1:0] pos_count,
  output logic [1:0] neg_count,
  input  logic       clk_in,
  input  logic       rst
`ifdef FREQ_DIV3_ENABLE_EN
  ,
  input  logic       en
`endif
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [CNT_W-1:0] {
    CNT0 = 2'd0,
    CNT1 = 2'd1,
    CNT2 = 2'd2
  } cnt_e;

  cnt_e pos_q;
  cnt_e pos_d;
  cnt_e neg_q;
  cnt_e neg_d;
  logic advance_c;

`ifdef FREQ_DIV3_ENABLE_EN
  assign advance_c = en;
`else
  assign advance_c = 1'b1;
`endif

  // Mod-3 step; the unused encoding 3 always recovers to 0, even while held
  function automatic cnt_e cnt_next(input cnt_e cur, input logic adv);
    cnt_e nxt;
    nxt = cur;
    if (CNT_W'(cur) == CNT_W'(3)) begin
      nxt = CNT0;
    end else if (adv) begin
      case (cur)
        CNT0:    nxt = CNT1;
        CNT1:    nxt = CNT2;
        default: nxt = CNT0;
      endcase
    end
    return nxt;
  endfunction

  always_comb begin
    pos_d = pos_q;
    neg_d = neg_q;
    pos_d = cnt_next(pos_q, advance_c);
    neg_d = cnt_next(neg_q, advance_c);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pos_q <= CNT0;
    end else begin
      pos_q <= pos_d;
    end
  end

  // Negedge counter trails the posedge counter by half a period
  always_ff @(negedge clk_in) begin
    if (rst) begin
      neg_q <= CNT0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign pos_count = CNT_W'(pos_q);
  assign neg_count = CNT_W'(neg_q);

  // Overlapping half-period-shifted decodes give a 1.5-period high phase
  assign clk_out = (pos_q == CNT2) | (neg_q == CNT2);

endmodule

// File: tb/tb_freq_divide_3.sv
// Scoreboard bench for freq_divide_3: directed expectations queued by stimulus, popped by a sampling monitor.
module tb_freq_divide_3;

  typedef struct {
    longint     t;
    logic [1:0] p;
    logic [1:0] n;
    logic       c;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       clk_out;
  logic [1:0] pos_count;
  logic [1:0] neg_count;
`ifdef FREQ_DIV3_ENABLE_EN
  logic       en     = 1'b1;
`endif

  int     errors = 0;
  int     checks = 0;
  exp_t   sb_q[$];
  longint edge_q[$];

  freq_divide_3 dut (
    .clk_out  (clk_out),
    .pos_count(pos_count),
    .neg_count(neg_count),
    .clk_in   (clk_in),
    .rst      (rst)
`ifdef FREQ_DIV3_ENABLE_EN
    ,
    .en       (en)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic expect_at(input longint t, input logic [1:0] p, input logic [1:0] n, input logic c);
    exp_t e;
    e.t = t;
    e.p = p;
    e.n = n;
    e.c = c;
    sb_q.push_back(e);
  endtask

  // Monitor: samples 1 unit after every clk_in edge
  initial begin
    exp_t e;
    forever begin
      @(clk_in);
      #1;
      while (sb_q.size() > 0 && sb_q[0].t <= $time) begin
        e = sb_q.pop_front();
        if (e.t != longint'($time)) check("sample_slot", 64'($time), 64'(e.t));
        check("pos_count", 64'(pos_count), 64'(e.p));
        check("neg_count", 64'(neg_count), 64'(e.n));
        check("clk_out", 64'(clk_out), 64'(e.c));
      end
      if (($time % 10) == 1 && $time > 10) begin
        check("pos_not3", 64'(pos_count == 2'd3), 64'd0);
        check("neg_not3", 64'(neg_count == 2'd3), 64'd0);
        check("neg_eq_pos", 64'(neg_count), 64'(pos_count));
      end
    end
  end

  // Records clk_out edges over the first 10 output periods after reset
  always @(clk_out) begin
    if ($time > 30 && $time < 340) edge_q.push_back(longint'($time));
  end

  initial begin
    expect_at(21, 2'd0, 2'd0, 1'b0);
    #22;
    rst = 1'b0;
    expect_at(26, 2'd1, 2'd0, 1'b0);
    expect_at(31, 2'd1, 2'd1, 1'b0);
    expect_at(36, 2'd2, 2'd1, 1'b1);
    expect_at(41, 2'd2, 2'd2, 1'b1);
    expect_at(46, 2'd0, 2'd2, 1'b1);
    expect_at(51, 2'd0, 2'd0, 1'b0);
    expect_at(56, 2'd1, 2'd0, 1'b0);
    expect_at(61, 2'd1, 2'd1, 1'b0);
    expect_at(66, 2'd2, 2'd1, 1'b1);
    expect_at(71, 2'd2, 2'd2, 1'b1);
    expect_at(76, 2'd0, 2'd2, 1'b1);
    expect_at(81, 2'd0, 2'd0, 1'b0);
    expect_at(366, 2'd2, 2'd1, 1'b1);
    expect_at(371, 2'd2, 2'd2, 1'b1);

    // Mid-operation reset while clk_out is high (t=372..382)
    #350;
    rst = 1'b1;
    expect_at(376, 2'd0, 2'd2, 1'b1);
    expect_at(381, 2'd0, 2'd0, 1'b0);
    #10;
    rst = 1'b0;
    expect_at(386, 2'd1, 2'd0, 1'b0);
    expect_at(391, 2'd1, 2'd1, 1'b0);
    expect_at(396, 2'd2, 2'd1, 1'b1);
    expect_at(401, 2'd2, 2'd2, 1'b1);
    expect_at(406, 2'd0, 2'd2, 1'b1);
    expect_at(411, 2'd0, 2'd0, 1'b0);

`ifdef FREQ_DIV3_ENABLE_EN
    // Freeze for two cycles while pos_count=1 (t=422..442)
    #40;
    en = 1'b0;
    expect_at(426, 2'd1, 2'd1, 1'b0);
    expect_at(436, 2'd1, 2'd1, 1'b0);
    expect_at(441, 2'd1, 2'd1, 1'b0);
    #20;
    en = 1'b1;
    expect_at(446, 2'd2, 2'd1, 1'b1);
    expect_at(451, 2'd2, 2'd2, 1'b1);
    expect_at(456, 2'd0, 2'd2, 1'b1);
`endif

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) #10;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    check("duty_edge_count", 64'(edge_q.size()), 64'd21);
    if (edge_q.size() > 0) check("first_rise_time", 64'(edge_q[0]), 64'd35);
    for (int i = 1; i < edge_q.size(); i++) begin
      check("duty_interval", 64'(edge_q[i] - edge_q[i-1]), 64'd15);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
